// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external RAM port between the I-side cache refill
// (BURST_LEN-word line bursts) and the D-side single-word load/store path.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int WORD_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [WORD_W-1:0] i_word,
    output logic              i_word_ready,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata,
    input  logic              ram_ack
);

    localparam int BYTES_PER_WORD = WORD_W / 8;
    localparam int LINE_OFF       = $clog2(BURST_LEN * BYTES_PER_WORD);
    localparam int WORD_OFF       = $clog2(BYTES_PER_WORD);
    localparam int BEAT_W         = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        I_BURST  = 2'd1,
        D_ACCESS = 2'd2
    } state_t;

    // Clear the low 'bits' address bits (line or word alignment).
    function automatic logic [ADDR_W-1:0] align_down(input logic [ADDR_W-1:0] addr,
                                                     input int unsigned bits);
        return (addr >> bits) << bits;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [BEAT_W-1:0]  beat_r;
    logic               last_i_r;
    logic               grant_i_s;
    logic               grant_d_s;
    logic               i_live_s;
    logic               d_live_s;
    logic               last_beat_s;

    logic [WORD_W-1:0]  i_word_r;
    logic               i_word_ready_r;
    logic               i_done_r;
    logic [WORD_W-1:0]  d_rdata_r;
    logic               d_ready_r;
    logic               ram_req_r;
    logic               ram_we_r;
    logic [ADDR_W-1:0]  ram_addr_r;
    logic [WORD_W-1:0]  ram_wdata_r;

    // The requester completing this cycle is masked so a held request is not regranted.
    assign i_live_s    = i_req & ~i_done_r;
    assign d_live_s    = d_req & ~d_ready_r;
    assign last_beat_s = (beat_r == LAST_BEAT);

    // Next-state and grant decision.
    always_comb begin
        state_s   = state_r;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_live_s && (!d_live_s || !last_i_r)) begin
                    state_s   = I_BURST;
                    grant_i_s = 1'b1;
                end else if (d_live_s) begin
                    state_s   = D_ACCESS;
                    grant_d_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            I_BURST: begin
                if (ram_ack && last_beat_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = I_BURST;
                end
            end
            D_ACCESS: begin
                if (ram_ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = D_ACCESS;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, beat counter and round-robin history (last_i_r=0 means D was last).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            beat_r   <= '0;
            last_i_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (grant_i_s) begin
                last_i_r <= 1'b1;
                beat_r   <= '0;
            end else if (grant_d_s) begin
                last_i_r <= 1'b0;
            end
            if (state_r == I_BURST && ram_ack) begin
                beat_r <= beat_r + BEAT_W'(1);
            end
        end
    end

    // RAM-side request, address and data, loaded only at grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_req_r   <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= '0;
            ram_wdata_r <= '0;
        end else begin
            ram_req_r <= (state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (grant_i_s) begin
                        ram_addr_r <= align_down(i_addr, LINE_OFF);
                        ram_we_r   <= 1'b0;
                    end else if (grant_d_s) begin
                        ram_addr_r  <= align_down(d_addr, WORD_OFF);
                        ram_we_r    <= d_we;
                        ram_wdata_r <= d_wdata;
                    end
                end
                I_BURST: begin
                    if (ram_ack && !last_beat_s) begin
                        ram_addr_r <= ram_addr_r + ADDR_STEP;
                    end
                end
                D_ACCESS: begin
                    if (ram_ack) begin
                        ram_we_r <= 1'b0;
                    end
                end
                default: begin
                    ram_we_r <= 1'b0;
                end
            endcase
        end
    end

    // Requester-side data capture and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_word_r       <= '0;
            i_word_ready_r <= 1'b0;
            i_done_r       <= 1'b0;
            d_rdata_r      <= '0;
            d_ready_r      <= 1'b0;
        end else begin
            i_word_ready_r <= (state_r == I_BURST) && ram_ack;
            i_done_r       <= (state_r == I_BURST) && ram_ack && last_beat_s;
            d_ready_r      <= (state_r == D_ACCESS) && ram_ack;
            if (state_r == I_BURST && ram_ack) begin
                i_word_r <= ram_rdata;
            end
            // Stores complete without disturbing the last load result.
            if (state_r == D_ACCESS && ram_ack && !ram_we_r) begin
                d_rdata_r <= ram_rdata;
            end
        end
    end

    assign i_word       = i_word_r;
    assign i_word_ready = i_word_ready_r;
    assign i_done       = i_done_r;
    assign d_rdata      = d_rdata_r;
    assign d_ready      = d_ready_r;
    assign ram_req      = ram_req_r;
    assign ram_we       = ram_we_r;
    assign ram_addr     = ram_addr_r;
    assign ram_wdata    = ram_wdata_r;

endmodule
